// File: rtl/reg_sum_gen.sv
// Purpose : step accumulator with parallel load, preset and a wrapping step counter;
//           build with REG_SUM_GEN_OVF_EN defined to get saturating steps and a sticky overflow flag.
// Latency : one cycle; every output is a flop.
// Backpressure : none; a step, load or hold is accepted every clock with no bubbles.
module reg_sum_gen #(
   parameter int unsigned      WIDTH       = 9,
   parameter int unsigned      CNT_W       = 5,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(1),
   parameter logic [WIDTH-1:0] SET_VALUE   = {{(WIDTH-1){1'b1}}, 1'b0},
   parameter int unsigned      STEP        = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             set,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] datain,
   output logic [WIDTH-1:0] dataout,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   // Increment at datapath width; STEP is bounded to 2^WIDTH-1, so nothing is lost.
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Reject parameter sets the datapath was not built for.
   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("reg_sum_gen: WIDTH must be in 2..32");
   end
   if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
      $error("reg_sum_gen: CNT_W must be in 1..16");
   end
   if (STEP < 1 || longint'(STEP) >= (longint'(1) << WIDTH)) begin : g_bad_step
      $error("reg_sum_gen: STEP must be in 1..2^WIDTH-1");
   end

   logic [WIDTH-1:0] dataout_q, dataout_d;
   logic [CNT_W-1:0] count_q,   count_d;
   logic [WIDTH-1:0] sum_lo;

   // Decoded operation for this edge; reset is handled in the register process.
   logic op_set, op_load, op_step;

   // Priority decode: set over load over step; anything else holds.
   always_comb begin
      op_set  = set;
      op_load = !set && enable && load;
      op_step = !set && enable && !load;
   end

`ifdef REG_SUM_GEN_OVF_EN
   logic overflow_q, overflow_d;
   logic carry;

   // Step adder with the carry kept; a carry (or a prior overflow) means saturation.
   always_comb begin
      {carry, sum_lo} = {1'b0, dataout_q} + {1'b0, STEP_W};
   end

   // Next-state: a saturated step freezes the counter and latches overflow until set/reset.
   always_comb begin
      dataout_d  = dataout_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (op_set) begin
         dataout_d  = SET_VALUE;
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (op_load) begin
         dataout_d  = datain;
      end else if (op_step) begin
         if (carry || overflow_q) begin
            dataout_d  = ALL_ONES;
            overflow_d = 1'b1;
         end else begin
            dataout_d  = sum_lo;
            count_d    = count_q + CNT_ONE;
         end
      end
   end

   // Overflow flag register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;
`else
   // Step adder; the carry is dropped, so the value simply wraps modulo 2^WIDTH.
   always_comb begin
      sum_lo = dataout_q + STEP_W;
   end

   // Next-state: every step advances both value and counter.
   always_comb begin
      dataout_d = dataout_q;
      count_d   = count_q;
      if (op_set) begin
         dataout_d = SET_VALUE;
         count_d   = '0;
      end else if (op_load) begin
         dataout_d = datain;
      end else if (op_step) begin
         dataout_d = sum_lo;
         count_d   = count_q + CNT_ONE;
      end
   end

   // Without the overflow option the flag is tied low.
   assign overflow = 1'b0;
`endif

   // Accumulator and step-counter registers; reset dominates every other control.
   always_ff @(posedge clock) begin
      if (reset) begin
         dataout_q <= RESET_VALUE;
         count_q   <= '0;
      end else begin
         dataout_q <= dataout_d;
         count_q   <= count_d;
      end
   end

   assign dataout = dataout_q;
   assign count   = count_q;

endmodule
